// File: rtl/score_event_scheduler.sv
// Per-lane hit queueing with round-robin grant; each grant becomes a paced
// burst of increment pulses whose length is the combo multiplier.
module score_event_scheduler #(
  parameter int NUM_LANES  = 4,
  parameter int PEND_W     = 3,
  parameter int PACE       = 2,
  parameter int COMBO_STEP = 8,
  parameter int MAX_MULT   = 4
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic                 clear,
  input  logic                 emit_enable,
  input  logic [NUM_LANES-1:0] hit,
  input  logic                 miss,
  output logic                 increment,
  output logic [NUM_LANES-1:0] grant,
  output logic                 busy,
  output logic [2:0]           multiplier,
  output logic [7:0]           combo,
  output logic                 dropped
);

  localparam int LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  typedef enum logic [1:0] {IDLE, EMIT, GAP} state_t;

  state_t               state;
  logic [PEND_W-1:0]    pending [NUM_LANES];
  logic [LANE_W-1:0]    last_lane;
  logic [LANE_W-1:0]    pick_lane;
  logic                 pick_found;
  logic                 grant_fire;
  logic                 sync_reset;
  logic [2:0]           points_left;
  logic [3:0]           gap_cnt;
  logic [NUM_LANES-1:0] grant_mask;
  logic [NUM_LANES-1:0] drop_mask;
  int                   search_idx;
  int                   mult_steps;
  int                   combo_sum;

  assign sync_reset = !resetn || clear;

  // Round-robin search starting just after the lane granted last.
  always_comb begin
    pick_found = 1'b0;
    pick_lane  = '0;
    search_idx = 0;
    for (int k = 1; k <= NUM_LANES; k++) begin
      search_idx = (int'(last_lane) + k) % NUM_LANES;
      if (!pick_found && pending[search_idx] != '0) begin
        pick_found = 1'b1;
        pick_lane  = LANE_W'(search_idx);
      end
    end
  end

  assign grant_fire = (state == IDLE) && emit_enable && pick_found;
  assign grant_mask = grant_fire ? (NUM_LANES'(1) << pick_lane) : '0;

  always_comb begin
    for (int i = 0; i < NUM_LANES; i++) begin
      drop_mask[i] = hit[i] && !grant_mask[i] && (pending[i] == PEND_MAX);
    end
  end

  always_comb begin
    mult_steps = int'(combo) / COMBO_STEP;
    if (mult_steps > MAX_MULT - 1) mult_steps = MAX_MULT - 1;
  end

  assign multiplier = 3'(mult_steps + 1);
  assign combo_sum  = int'(combo) + $countones(hit);

  always_ff @(posedge clock) begin
    if (sync_reset) begin
      for (int i = 0; i < NUM_LANES; i++) pending[i] <= '0;
      dropped <= 1'b0;
      combo   <= 8'd0;
    end else begin
      for (int i = 0; i < NUM_LANES; i++) begin
        case ({hit[i], grant_mask[i]})
          2'b10:   if (pending[i] != PEND_MAX) pending[i] <= pending[i] + 1'b1;
          2'b01:   pending[i] <= pending[i] - 1'b1;
          default: pending[i] <= pending[i];
        endcase
      end
      dropped <= |drop_mask;
      // A miss wipes the streak even if hits land in the same cycle.
      if (miss)                combo <= 8'd0;
      else if (combo_sum > 255) combo <= 8'd255;
      else                      combo <= 8'(combo_sum);
    end
  end

  always_ff @(posedge clock) begin
    if (sync_reset) begin
      state       <= IDLE;
      increment   <= 1'b0;
      busy        <= 1'b0;
      grant       <= '0;
      points_left <= 3'd0;
      gap_cnt     <= 4'd0;
      last_lane   <= LANE_W'(NUM_LANES - 1);
    end else begin
      increment <= 1'b0;
      unique case (state)
        IDLE: begin
          if (grant_fire) begin
            state       <= EMIT;
            increment   <= 1'b1;
            busy        <= 1'b1;
            grant       <= grant_mask;
            points_left <= multiplier;
            last_lane   <= pick_lane;
          end
        end
        EMIT: begin
          points_left <= points_left - 3'd1;
          if (PACE == 1) begin
            if (points_left > 3'd1) begin
              state     <= EMIT;
              increment <= 1'b1;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
              grant <= '0;
            end
          end else begin
            state   <= GAP;
            gap_cnt <= 4'(PACE - 1);
          end
        end
        GAP: begin
          // Leaving on the count that reaches zero keeps pulses PACE apart.
          if (gap_cnt <= 4'd1) begin
            gap_cnt <= 4'd0;
            if (points_left != 3'd0) begin
              state     <= EMIT;
              increment <= 1'b1;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
              grant <= '0;
            end
          end else begin
            gap_cnt <= gap_cnt - 4'd1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          grant <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_score_event_scheduler.sv
// Scoreboard bench: a cycle-level reference model predicts burst pulses and
// drops into queues that a negedge monitor pops whenever the DUT emits.
module tb_score_event_scheduler;

  localparam int N        = 4;
  localparam int PEND_MAX = 7;
  localparam int PACE     = 2;
  localparam int STEP     = 8;
  localparam int MAXM     = 4;

  logic         clock       = 1'b0;
  logic         resetn      = 1'b0;
  logic         clear       = 1'b0;
  logic         emit_enable = 1'b0;
  logic [N-1:0] hit         = '0;
  logic         miss        = 1'b0;
  logic         increment;
  logic [N-1:0] grant;
  logic         busy;
  logic [2:0]   multiplier;
  logic [7:0]   combo;
  logic         dropped;

  score_event_scheduler #(
    .NUM_LANES(N), .PEND_W(3), .PACE(PACE), .COMBO_STEP(STEP), .MAX_MULT(MAXM)
  ) dut (
    .clock(clock), .resetn(resetn), .clear(clear), .emit_enable(emit_enable),
    .hit(hit), .miss(miss), .increment(increment), .grant(grant), .busy(busy),
    .multiplier(multiplier), .combo(combo), .dropped(dropped)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    int lane;
  } pulse_t;

  pulse_t pulse_q[$];
  int     drop_q[$];

  int m_pend[N];
  int m_combo;
  int m_last;
  int m_idle_at;
  int m_lane;
  bit checks_on = 1'b0;

  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("[TB] FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
  endtask

  function automatic int model_mult();
    int s;
    s = m_combo / STEP;
    if (s > MAXM - 1) s = MAXM - 1;
    return s + 1;
  endfunction

  task automatic checkOutput();
    int busy_exp;
    if (checks_on) begin
      busy_exp = (cyc < m_idle_at) ? 1 : 0;
      check("combo", int'(combo), m_combo);
      check("multiplier", int'(multiplier), model_mult());
      check("busy", int'(busy), busy_exp);
      check("grant", int'(grant), busy_exp ? (1 << m_lane) : 0);
    end
  endtask

  // Advances the reference model by the inputs applied in the current cycle.
  task automatic modelStep(input logic [N-1:0] h, input logic ms, input logic en,
                           input logic clr, input logic rn);
    int c;
    int gl;
    int m;
    int idx;
    bit drop;
    c = cyc;
    if (!rn || clr) begin
      for (int i = 0; i < N; i++) m_pend[i] = 0;
      m_combo   = 0;
      m_last    = N - 1;
      m_idle_at = c + 1;
      m_lane    = 0;
      while (pulse_q.size() > 0 && pulse_q[$].cyc > c) void'(pulse_q.pop_back());
      checks_on = 1'b1;
      return;
    end
    gl = -1;
    if (c >= m_idle_at && en) begin
      for (int k = 1; k <= N; k++) begin
        idx = (m_last + k) % N;
        if (gl < 0 && m_pend[idx] > 0) gl = idx;
      end
    end
    if (gl >= 0) begin
      m = model_mult();
      for (int k = 0; k < m; k++) pulse_q.push_back('{cyc: c + 1 + k * PACE, lane: gl});
      m_idle_at = c + 1 + m * PACE;
      m_last    = gl;
      m_lane    = gl;
    end
    drop = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (h[i] && i != gl) begin
        if (m_pend[i] == PEND_MAX) drop = 1'b1;
        else m_pend[i]++;
      end else if (!h[i] && i == gl) begin
        m_pend[i]--;
      end
    end
    if (drop) drop_q.push_back(c + 1);
    if (ms) m_combo = 0;
    else begin
      m_combo += $countones(h);
      if (m_combo > 255) m_combo = 255;
    end
  endtask

  task automatic applyStimulus(input logic [N-1:0] h, input logic ms, input logic en,
                               input logic clr, input logic rn);
    @(posedge clock);
    #1;
    checkOutput();
    modelStep(h, ms, en, clr, rn);
    hit         = h;
    miss        = ms;
    emit_enable = en;
    clear       = clr;
    resetn      = rn;
  endtask

  // Monitor: every increment or dropped pulse must match the head of its queue.
  always @(negedge clock) begin
    pulse_t p;
    if (checks_on) begin
      while (pulse_q.size() > 0 && pulse_q[0].cyc < cyc) begin
        check("increment_missing", 0, 1);
        void'(pulse_q.pop_front());
      end
      if (increment) begin
        if (pulse_q.size() == 0 || pulse_q[0].cyc != cyc) check("increment_unexpected", 1, 0);
        else begin
          p = pulse_q.pop_front();
          check("increment_grant", int'(grant), 1 << p.lane);
        end
      end
      while (drop_q.size() > 0 && drop_q[0] < cyc) begin
        check("dropped_missing", 0, 1);
        void'(drop_q.pop_front());
      end
      if (dropped) begin
        if (drop_q.size() == 0 || drop_q[0] != cyc) check("dropped_unexpected", 1, 0);
        else begin
          void'(drop_q.pop_front());
          check("dropped", int'(dropped), 1);
        end
      end
    end
  end

  task automatic idle(input int n, input logic en);
    for (int i = 0; i < n; i++) applyStimulus('0, 1'b0, en, 1'b0, 1'b1);
  endtask

  initial begin
    bit          emit_next;
    logic [N-1:0] h;
    logic        en;
    int          waited;

    applyStimulus('0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus('0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(2, 1'b1);

    applyStimulus(4'b0100, 1'b0, 1'b1, 1'b0, 1'b1);
    idle(6, 1'b1);

    applyStimulus(4'b1011, 1'b0, 1'b1, 1'b0, 1'b1);
    idle(12, 1'b1);

    applyStimulus('0, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 9; i++) applyStimulus(4'b0001, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(2, 1'b0);
    idle(50, 1'b1);

    applyStimulus('0, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 9; i++) applyStimulus(4'b1000, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(2, 1'b0);
    idle(40, 1'b1);

    applyStimulus('0, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 20; i++) applyStimulus(N'(1) << (i % N), 1'b0, 1'b0, 1'b0, 1'b1);
    idle(1, 1'b0);
    applyStimulus(4'b0010, 1'b1, 1'b0, 1'b0, 1'b1);
    emit_next = 1'b0;
    waited = 0;
    while (!emit_next && waited < 60) begin
      applyStimulus('0, 1'b0, 1'b1, 1'b0, 1'b1);
      foreach (pulse_q[j]) if (pulse_q[j].cyc == cyc + 1) emit_next = 1'b1;
      waited++;
    end
    if (!emit_next) check("emit_wait_timeout", waited, 0);
    applyStimulus('0, 1'b0, 1'b1, 1'b1, 1'b1);
    idle(10, 1'b1);

    for (int i = 0; i < 700; i++) begin
      h  = N'($urandom & $urandom);
      en = ((i / 60) % 2 == 0) ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 9) < 2);
      applyStimulus(h, $urandom_range(0, 19) == 0, en,
                    $urandom_range(0, 199) == 0, $urandom_range(0, 299) != 0);
    end

    waited = 0;
    while ((pulse_q.size() > 0 || drop_q.size() > 0 || cyc <= m_idle_at) && waited < 300) begin
      applyStimulus('0, 1'b0, 1'b0, 1'b0, 1'b1);
      waited++;
    end
    idle(2, 1'b0);
    check("leftover_pulses", pulse_q.size(), 0);
    check("leftover_drops", drop_q.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
